adc_fft_framer: RTL and testbench

- Consumes the two's-complement ADC sample stream produced by the offset-binary to two's-complement stage, one sample per in_valid.
- Sign-extends each sample and packs the stream into fixed-length AXI-Stream frames with tlast for the FFT core.
- Buffers samples through a small first-word-fall-through FIFO.
- Frames are always exactly FFT_LEN long: on FIFO overflow the rest of the frame is zero-padded and the frame is counted as corrupted.

---
 rtl/adc_fft_framer_if.sv | 30 +++
 rtl/adc_fft_framer.sv | 191 +++++++++++++++++++
 tb/tb_adc_fft_framer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_fft_framer_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_fft_framer_if
// Description : AXI-Stream style output bundle for the ADC-to-FFT framer:
//               {imag, real} data word, valid/ready handshake and last flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_fft_framer_if #(
    parameter int OUTWIDTH = 16
);
    logic [2*OUTWIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/adc_fft_framer.sv
`default_nettype none
// ============================================================================
// Module      : adc_fft_framer
// Description : Sign-extends two's-complement ADC samples and packs them into
//               fixed-length frames (tlast on word N-1) through a small FWFT
//               FIFO. An overflow zero-pads the rest of the frame so every
//               frame the FFT sees is exactly N words long.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_fft_framer #(
    parameter int DATAWIDTH       = 14,
    parameter int OUTWIDTH        = 16,
    parameter int FFT_LEN_LOG2    = 10,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  wire                          adc_clk,
    input  wire                          adc_rstn,
    input  wire                          enable,
    input  wire                          clr,
    input  wire                          in_valid,
    input  wire  [DATAWIDTH-1:0]         data_2c,
    adc_fft_framer_if.master             m_axis,
    output logic [31:0]                  frame_cnt,
    output logic [15:0]                  drop_cnt,
    output logic                         overflow
);

    localparam int unsigned                 c_depth    = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FFT_LEN_LOG2-1:0]     c_last_idx = '1;
    localparam logic [15:0]                 c_drop_max = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PAD  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [FFT_LEN_LOG2-1:0]    idx_q, idx_d;
    logic [FIFO_DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]                frame_cnt_q, frame_cnt_d;
    logic [15:0]                drop_cnt_q, drop_cnt_d;
    logic                       overflow_q, overflow_d;

    // Each entry is {last, sample}; storage is not reset, reads are masked by empty.
    logic [OUTWIDTH:0]          mem_q [c_depth];

    logic [OUTWIDTH-1:0]        w_sample;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_pop;
    logic                       w_wr_en;
    logic [OUTWIDTH-1:0]        w_wr_data;
    logic                       w_wr_last;
    logic                       w_ovf_evt;
    logic [OUTWIDTH:0]          w_head;

    // Sign extension of the input sample to the output real-part width.
    generate
        if (OUTWIDTH > DATAWIDTH) begin : g_sext
            assign w_sample = {{(OUTWIDTH-DATAWIDTH){data_2c[DATAWIDTH-1]}}, data_2c};
        end else begin : g_nosext
            assign w_sample = data_2c;
        end
    endgenerate

    // FIFO status: extra pointer MSB distinguishes full from empty.
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[FIFO_DEPTH_LOG2] != rd_ptr_q[FIFO_DEPTH_LOG2]) &&
                     (wr_ptr_q[FIFO_DEPTH_LOG2-1:0] == rd_ptr_q[FIFO_DEPTH_LOG2-1:0]);
    assign w_head  = mem_q[rd_ptr_q[FIFO_DEPTH_LOG2-1:0]];
    assign w_pop   = !w_empty && m_axis.tready;

    // Output side is driven straight from FIFO state; data is zero when empty.
    assign m_axis.tvalid = !w_empty;
    assign m_axis.tlast  = !w_empty && w_head[OUTWIDTH];
    assign m_axis.tdata  = w_empty ? '0 : {{OUTWIDTH{1'b0}}, w_head[OUTWIDTH-1:0]};
    assign frame_cnt     = frame_cnt_q;
    assign drop_cnt      = drop_cnt_q;
    assign overflow      = overflow_q;

    // Framing FSM: decides FIFO writes, index advance and overflow events.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        w_wr_en   = 1'b0;
        w_wr_data = '0;
        w_wr_last = (idx_q == c_last_idx);
        w_ovf_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && in_valid) begin
                    if (!w_full) begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_sample;
                        idx_d     = idx_q + 1'b1;
                        state_d   = ST_RUN;
                    end else begin
                        w_ovf_evt = 1'b1;
                        idx_d     = '0;
                        state_d   = ST_PAD;
                    end
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    if (!w_full) begin
                        w_wr_en   = 1'b1;
                        w_wr_data = w_sample;
                        idx_d     = idx_q + 1'b1;
                        if (idx_q == c_last_idx) begin
                            state_d = enable ? ST_RUN : ST_IDLE;
                        end
                    end else begin
                        // Lost sample: its index is the first one padded.
                        w_ovf_evt = 1'b1;
                        state_d   = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                if (!w_full) begin
                    w_wr_en = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == c_last_idx) begin
                        state_d = enable ? ST_RUN : ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Pointer and status counter next-state; clr wins over increment/set.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + {{FIFO_DEPTH_LOG2{1'b0}}, w_wr_en};
        rd_ptr_d    = rd_ptr_q + {{FIFO_DEPTH_LOG2{1'b0}}, w_pop};
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        overflow_d  = overflow_q;
        if (clr) begin
            frame_cnt_d = '0;
            drop_cnt_d  = '0;
            overflow_d  = 1'b0;
        end else begin
            if (w_pop && w_head[OUTWIDTH]) begin
                frame_cnt_d = frame_cnt_q + 32'd1;
            end
            if (w_ovf_evt) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != c_drop_max) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge adc_clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q[FIFO_DEPTH_LOG2-1:0]] <= {w_wr_last, w_wr_data};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_fft_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_fft_framer
// Description : Directed self-checking bench for adc_fft_framer with N=8, D=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_fft_framer;

    logic        adc_clk = 1'b0;
    logic        adc_rstn;
    logic        enable;
    logic        clr;
    logic        in_valid;
    logic [13:0] data_2c;
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;
    logic        overflow;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    adc_fft_framer_if #(.OUTWIDTH(16)) m_axis ();

    adc_fft_framer #(
        .DATAWIDTH      (14),
        .OUTWIDTH       (16),
        .FFT_LEN_LOG2   (3),
        .FIFO_DEPTH_LOG2(2)
    ) dut (
        .adc_clk  (adc_clk),
        .adc_rstn (adc_rstn),
        .enable   (enable),
        .clr      (clr),
        .in_valid (in_valid),
        .data_2c  (data_2c),
        .m_axis   (m_axis),
        .frame_cnt(frame_cnt),
        .drop_cnt (drop_cnt),
        .overflow (overflow)
    );

    always #5 adc_clk = ~adc_clk;

    logic [13:0] t2_in  [4] = '{14'h1FFF, 14'h2000, 14'h3FFF, 14'h0000};
    logic [15:0] t2_exp [4] = '{16'h1FFF, 16'hE000, 16'hFFFF, 16'h0000};
    logic [13:0] t3_in  [8] = '{14'h2ABC, 14'h0011, 14'h3000, 14'h0FFF,
                                14'h0044, 14'h0055, 14'h0066, 14'h0077};
    logic [15:0] t3_exp [4] = '{16'hEABC, 16'h0011, 16'hF000, 16'h0FFF};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] d, input logic l);
        check({tag, ".tvalid"}, 32'(m_axis.tvalid), 32'(v));
        if (v) begin
            check({tag, ".tdata"}, m_axis.tdata, {16'h0000, d});
            check({tag, ".tlast"}, 32'(m_axis.tlast), 32'(l));
        end
    endtask

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    initial begin
        adc_rstn      = 1'b0;
        enable        = 1'b0;
        clr           = 1'b0;
        in_valid      = 1'b0;
        data_2c       = '0;
        m_axis.tready = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst.tvalid", 32'(m_axis.tvalid), 32'd0);
        check("rst.tdata", m_axis.tdata, 32'd0);
        check("rst.tlast", 32'(m_axis.tlast), 32'd0);
        check("rst.frame_cnt", frame_cnt, 32'd0);
        check("rst.drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst.overflow", 32'(overflow), 32'd0);
        adc_rstn = 1'b1;
        tick();

        // Continuous stream, two frames, sign extension
        enable        = 1'b1;
        m_axis.tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            data_2c  = t2_in[i % 4];
            tick();
            check_out("stream", 1'b1, t2_exp[i % 4], (i % 8) == 7);
            check("stream.frame_cnt", frame_cnt, (i >= 8) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        tick();
        check_out("stream.drain", 1'b0, 16'h0, 1'b0);
        check("stream.frame_cnt_end", frame_cnt, 32'd2);

        // Gapped input: index advances only on valid
        for (int i = 0; i < 16; i++) begin
            in_valid = (i % 2) == 0;
            data_2c  = 14'h0100 + 14'(i);
            tick();
            if ((i % 2) == 0) check_out("gap", 1'b1, 16'h0100 + 16'(i), i == 14);
            else              check_out("gap.idle", 1'b0, 16'h0, 1'b0);
        end
        check("gap.frame_cnt", frame_cnt, 32'd3);
        check("gap.overflow", 32'(overflow), 32'd0);

        // Enable dropped mid-frame: frame completes, then input ignored
        for (int i = 0; i < 12; i++) begin
            enable   = (i < 3);
            in_valid = 1'b1;
            data_2c  = 14'h0200 + 14'(i);
            tick();
            if (i < 8) check_out("en_off", 1'b1, 16'h0200 + 16'(i), i == 7);
            else       check_out("en_off.idle", 1'b0, 16'h0, 1'b0);
        end
        check("en_off.frame_cnt", frame_cnt, 32'd4);
        enable = 1'b1;
        for (int j = 0; j < 8; j++) begin
            in_valid = 1'b1;
            data_2c  = 14'h3F00 + 14'(j);
            tick();
            check_out("en_on", 1'b1, 16'hFF00 + 16'(j), j == 7);
        end
        in_valid = 1'b0;
        tick();
        check("en_on.frame_cnt", frame_cnt, 32'd5);

        // Backpressure overflow: 4 stored, rest of frame zero-padded
        m_axis.tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            data_2c  = t3_in[i];
            tick();
            check_out("ovf.hold", 1'b1, 16'hEABC, 1'b0);
            check("ovf.overflow", 32'(overflow), (i >= 4) ? 32'd1 : 32'd0);
            check("ovf.drop_cnt", 32'(drop_cnt), (i >= 4) ? 32'd1 : 32'd0);
        end
        in_valid      = 1'b0;
        m_axis.tready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            check_out("ovf.drain", 1'b1, (k < 3) ? t3_exp[k + 1] : 16'h0000, k == 6);
        end
        tick();
        check_out("ovf.empty", 1'b0, 16'h0, 1'b0);
        check("ovf.frame_cnt", frame_cnt, 32'd6);
        check("ovf.drop_once", 32'(drop_cnt), 32'd1);

        // clr coincident with a tlast handshake
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            data_2c  = 14'h0600 + 14'(i);
            tick();
            check_out("clr.frame", 1'b1, 16'h0600 + 16'(i), i == 7);
        end
        in_valid = 1'b0;
        clr      = 1'b1;
        tick();
        clr = 1'b0;
        check("clr.frame_cnt", frame_cnt, 32'd0);
        check("clr.drop_cnt", 32'(drop_cnt), 32'd0);
        check("clr.overflow", 32'(overflow), 32'd0);
        check_out("clr.empty", 1'b0, 16'h0, 1'b0);

        // Reset mid-frame with FIFO non-empty and counters non-zero
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            data_2c  = 14'h0700 + 14'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("pre_rst.frame_cnt", frame_cnt, 32'd1);
        m_axis.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            data_2c  = 14'h0800 + 14'(i);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst.overflow", 32'(overflow), 32'd1);
        check("pre_rst.tvalid", 32'(m_axis.tvalid), 32'd1);
        #2;
        adc_rstn = 1'b0;
        #1;
        check("async_rst.tvalid", 32'(m_axis.tvalid), 32'd0);
        check("async_rst.tdata", m_axis.tdata, 32'd0);
        check("async_rst.tlast", 32'(m_axis.tlast), 32'd0);
        check("async_rst.frame_cnt", frame_cnt, 32'd0);
        check("async_rst.drop_cnt", 32'(drop_cnt), 32'd0);
        check("async_rst.overflow", 32'(overflow), 32'd0);
        tick();
        adc_rstn      = 1'b1;
        m_axis.tready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            in_valid = 1'b1;
            data_2c  = 14'h1000 + 14'(j);
            tick();
            check_out("post_rst", 1'b1, 16'h1000 + 16'(j), j == 7);
        end
        in_valid = 1'b0;
        tick();
        check("post_rst.frame_cnt", frame_cnt, 32'd1);
        check_out("post_rst.empty", 1'b0, 16'h0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
